// File: rtl/nes_pad_port.sv
// NES controller port: synchronised button input latched into a CD4021-style shift register.
// Optional per-bit debounce is enabled by defining NES_PAD_DEBOUNCE_EN.
module nes_pad_port #(
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] buttons_in,
  input  logic       strobe,
  input  logic       read_pulse,
  output logic       data_out,
  output logic       empty,
  output logic [7:0] buttons_dbg
);

  localparam logic [7:0] RELEASED_LEVEL = ACTIVE_LOW ? 8'hFF : 8'h00;

  logic [7:0] syncMeta_q;
  logic [7:0] syncOut_q;
  logic [7:0] syncBtn;
  logic [7:0] btn;

  logic [7:0] sr_q, sr_d;
  logic [3:0] cnt_q, cnt_d;
  logic       empty_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      syncMeta_q <= RELEASED_LEVEL;
      syncOut_q  <= RELEASED_LEVEL;
    end else begin
      syncMeta_q <= buttons_in;
      syncOut_q  <= syncMeta_q;
    end
  end

  assign syncBtn = ACTIVE_LOW ? ~syncOut_q : syncOut_q;

`ifdef NES_PAD_DEBOUNCE_EN
  logic [15:0] debCnt_q [8];
  logic [7:0]  deb_q;

  // A bit flips only after DEBOUNCE_CYCLES consecutive samples disagree with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_q <= 8'h00;
      for (int i = 0; i < 8; i++) begin
        debCnt_q[i] <= 16'd0;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (syncBtn[i] == deb_q[i]) begin
          debCnt_q[i] <= 16'd0;
        end else if (debCnt_q[i] == DEBOUNCE_CYCLES - 16'd1) begin
          deb_q[i]    <= syncBtn[i];
          debCnt_q[i] <= 16'd0;
        end else begin
          debCnt_q[i] <= debCnt_q[i] + 16'd1;
        end
      end
    end
  end

  assign btn = deb_q;
`else
  assign btn = syncBtn;
`endif

  // Strobe reloads continuously and overrides reads; shifting fills with 1 like a real pad.
  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (strobe) begin
      sr_d  = btn;
      cnt_d = 4'd0;
    end else if (read_pulse) begin
      sr_d  = {1'b1, sr_q[7:1]};
      cnt_d = (cnt_q == 4'd8) ? 4'd8 : cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q    <= 8'h00;
      cnt_q   <= 4'd0;
      empty_q <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      empty_q <= (cnt_d == 4'd8);
    end
  end

  assign data_out    = sr_q[0];
  assign empty       = empty_q;
  assign buttons_dbg = btn;

endmodule

// File: tb/tb_nes_pad_port.sv
// Scoreboard bench for nes_pad_port; debounce checks run when NES_PAD_DEBOUNCE_EN is defined.
module tb_nes_pad_port;

  localparam int DEB = 4;
`ifdef NES_PAD_DEBOUNCE_EN
  localparam int BTN_LAT = 2 + DEB;
`else
  localparam int BTN_LAT = 2;
`endif

  logic       clk        = 1'b0;
  logic       rst_n      = 1'b0;
  logic [7:0] buttons_in = 8'hFF;
  logic       strobe     = 1'b0;
  logic       read_pulse = 1'b0;
  logic       data_out;
  logic       empty;
  logic [7:0] buttons_dbg;

  int checks   = 0;
  int failures = 0;
  logic sbQueue[$];

  nes_pad_port #(
    .ACTIVE_LOW      (1'b1),
    .DEBOUNCE_CYCLES (16'(DEB))
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .buttons_in  (buttons_in),
    .strobe      (strobe),
    .read_pulse  (read_pulse),
    .data_out    (data_out),
    .empty       (empty),
    .buttons_dbg (buttons_dbg)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%02h expected=0x%02h", tag, observed, expected);
    end
  endtask

  // Latch a pattern and queue the pressed-high bits the CPU should read, bit 0 first.
  task automatic applyStimulus(input logic [7:0] btns);
    @(negedge clk);
    buttons_in = btns;
    strobe     = 1'b1;
    repeat (BTN_LAT + 2) @(negedge clk);
    strobe = 1'b0;
    for (int i = 0; i < 8; i++) sbQueue.push_back(~btns[i]);
  endtask

  task automatic doReads(input int n, input bit backToBack, input string tag);
    logic expBit;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      read_pulse = 1'b1;
      expBit = (sbQueue.size() > 0) ? sbQueue.pop_front() : 1'b1;
      checkOutput($sformatf("%s[%0d]", tag, i), {7'd0, data_out}, {7'd0, expBit});
      if (!backToBack) begin
        @(negedge clk);
        read_pulse = 1'b0;
      end
    end
    @(negedge clk);
    read_pulse = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset_data", {7'd0, data_out}, 8'h00);
    checkOutput("reset_empty", {7'd0, empty}, 8'h00);
    checkOutput("reset_dbg", buttons_dbg, 8'h00);
    repeat (4) @(negedge clk);
    checkOutput("idle_dbg", buttons_dbg, 8'h00);

    applyStimulus(8'hFE);
    checkOutput("latchA_empty", {7'd0, empty}, 8'h00);
    doReads(8, 1'b0, "readA");
    checkOutput("readA_empty", {7'd0, empty}, 8'h01);
    doReads(3, 1'b0, "fill");
    checkOutput("fill_empty", {7'd0, empty}, 8'h01);

    applyStimulus(8'h5A);
    checkOutput("latch5A_empty", {7'd0, empty}, 8'h00);
    doReads(8, 1'b1, "b2b");
    checkOutput("b2b_empty", {7'd0, empty}, 8'h01);

    // Strobe held high: reads are ignored and data_out follows the live A bit.
    @(negedge clk);
    buttons_in = 8'hFE;
    strobe     = 1'b1;
    repeat (BTN_LAT + 2) @(negedge clk);
    checkOutput("hold_data", {7'd0, data_out}, 8'h01);
    buttons_in = 8'hFF;
    read_pulse = 1'b1;
    for (int c = 1; c <= BTN_LAT + 3; c++) begin
      @(negedge clk);
      if (c == 5) read_pulse = 1'b0;
      checkOutput($sformatf("hold_data_c%0d", c), {7'd0, data_out}, (c >= BTN_LAT + 1) ? 8'h00 : 8'h01);
      checkOutput($sformatf("hold_dbg_c%0d", c), buttons_dbg, (c >= BTN_LAT) ? 8'h00 : 8'h01);
    end
    read_pulse = 1'b0;
    checkOutput("hold_empty", {7'd0, empty}, 8'h00);
    strobe = 1'b0;

    // Reset in the middle of a read sequence.
    applyStimulus(8'h00);
    doReads(3, 1'b0, "preReset");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midReset_data", {7'd0, data_out}, 8'h00);
    checkOutput("midReset_empty", {7'd0, empty}, 8'h00);
    sbQueue.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) sbQueue.push_back(1'b0);
    doReads(9, 1'b0, "postReset");
    checkOutput("postReset_empty", {7'd0, empty}, 8'h01);
    checkOutput("postReset_dbg", buttons_dbg, 8'hFF);

`ifdef NES_PAD_DEBOUNCE_EN
    @(negedge clk);
    buttons_in = 8'hFF;
    repeat (BTN_LAT + 4) @(negedge clk);
    checkOutput("deb_settle", buttons_dbg, 8'h00);
    buttons_in = 8'hFD;
    repeat (3) @(negedge clk);
    buttons_in = 8'hFF;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checkOutput($sformatf("deb_glitch_%0d", k), buttons_dbg, 8'h00);
    end
    buttons_in = 8'hFD;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checkOutput($sformatf("deb_press_%0d", k), buttons_dbg, (k >= 6) ? 8'h02 : 8'h00);
      if (k == 6) buttons_in = 8'hFF;
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
